debounce_edge: RTL

- Per-bit debouncer and edge detector placed directly after the two-flop synchronizer stage for mechanical/slow inputs (buttons, switches, jumpers).
- Accepts already-synchronized bits and publishes a clean level per bit once the input has held a new value for a programmable number of consecutive clocks.
- Emits single-cycle rise/fall pulses on each accepted transition.
- Channels are fully independent.

---
 rtl/debounce_edge.sv | 80 ++++++++
 1 files changed

// File: rtl/debounce_edge.sv
// Per-bit debouncer with rise/fall pulse outputs.
// Each channel publishes a new level only after the input has disagreed with
// the published level for p_STABLE_CYCLES consecutive clocks. A single
// agreeing sample restarts the count. Inputs must already be synchronized
// to i_clk.
module debounce_edge #(
    parameter int p_WIDTH         = 1,
    parameter int p_STABLE_CYCLES = 16,
    parameter int p_CNT_WIDTH     = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [p_WIDTH-1:0] iv_input,
    output logic [p_WIDTH-1:0] ov_state,
    output logic [p_WIDTH-1:0] ov_rise,
    output logic [p_WIDTH-1:0] ov_fall
);

    // Largest count the stability counter can represent plus one.
    localparam longint LP_CNT_SPAN = longint'(1) << p_CNT_WIDTH;

    // Terminal count: reaching it on a differing sample accepts the new level.
    // Counting starts at 0 on the first differing sample, so the counter never
    // needs to hold a value above p_STABLE_CYCLES-1.
    localparam logic [p_CNT_WIDTH-1:0] LP_LAST = p_CNT_WIDTH'(p_STABLE_CYCLES - 1);

    generate
        if (p_STABLE_CYCLES < 1 || longint'(p_STABLE_CYCLES) > LP_CNT_SPAN) begin : g_bad_param
            $error("debounce_edge: p_STABLE_CYCLES must lie in 1..2**p_CNT_WIDTH");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < p_WIDTH; gi++) begin : g_chan
            logic [p_CNT_WIDTH-1:0] cnt_q, cnt_d;
            logic                   state_q, state_d;
            logic                   rise_q, rise_d;
            logic                   fall_q, fall_d;

            // Next-state: clear the count on agreement, advance it on
            // disagreement, and accept the new level at the terminal count.
            always_comb begin
                cnt_d   = '0;
                state_d = state_q;
                rise_d  = 1'b0;
                fall_d  = 1'b0;
                if (iv_input[gi] != state_q) begin
                    if (cnt_q == LP_LAST) begin
                        state_d = iv_input[gi];
                        rise_d  = iv_input[gi];
                        fall_d  = ~iv_input[gi];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            // Channel registers; reset discards any partial count immediately.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    cnt_q   <= '0;
                    state_q <= 1'b0;
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    state_q <= state_d;
                    rise_q  <= rise_d;
                    fall_q  <= fall_d;
                end
            end

            assign ov_state[gi] = state_q;
            assign ov_rise[gi]  = rise_q;
            assign ov_fall[gi]  = fall_q;
        end
    endgenerate

endmodule
